// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: one-at-a-time load/store sequencer between the memory
// stage and a valid/ready data bus. Aligns addresses, builds byte strobes,
// lane-shifts store data and extracts/extends load data.
// Optional response watchdog: define LSU_TIMEOUT_EN.
module lsu_access_ctrl #(
    parameter int WIDTH          = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_op,
    input  logic [WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 resp_fault,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH/8-1:0]   mem_wstrb,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam int NBYTES = WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic              we_q;
    logic [2:0]        op_q;
    logic [OFFW-1:0]   off_q;
    logic              fault_q;
    logic [WIDTH-1:0]  resp_data_q;

    logic [1:0]        req_size;
    logic [OFFW-1:0]   req_off;
    logic [2:0]        align_mask;
    logic [NBYTES-1:0] size_lanes;
    logic              req_bad;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  load_ext;
    logic              rsp_take;
    logic              to_expire;
    logic              timeout;

    assign req_size = req_op[1:0];
    assign req_off  = req_addr[OFFW-1:0];

    // Request decode: alignment mask, lane mask and legality
    always_comb begin
        align_mask = 3'b111;
        size_lanes = '1;
        case (req_size)
            2'd0: begin align_mask = 3'b000; size_lanes = NBYTES'(1);  end
            2'd1: begin align_mask = 3'b001; size_lanes = NBYTES'(3);  end
            2'd2: begin align_mask = 3'b011; size_lanes = NBYTES'(15); end
            default: ;
        endcase
        req_bad = (|(req_addr[2:0] & align_mask))
                | (!req_we && req_op == 3'd7)
                | ((WIDTH == 32) && req_size == 2'd3)
                | ((WIDTH == 32) && !req_we && req_op == 3'd6);
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    // Load extraction from the live bus data, using the captured op/offset
    always_comb begin
        case (op_q)
            3'd0:    load_ext = WIDTH'($signed(shifted[7:0]));
            3'd1:    load_ext = WIDTH'($signed(shifted[15:0]));
            3'd2:    load_ext = WIDTH'($signed(shifted[31:0]));
            3'd4:    load_ext = WIDTH'(shifted[7:0]);
            3'd5:    load_ext = WIDTH'(shifted[15:0]);
            3'd6:    load_ext = WIDTH'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    assign rsp_take  = (state == REQ && mem_gnt && mem_rvalid)
                     | (state == WAIT && mem_rvalid);
    assign to_expire = timeout && ((state == REQ && !mem_gnt)
                                 | (state == WAIT && !mem_rvalid));

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;

    // Watchdog: cleared on entry to REQ, counts every REQ/WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= '0;
        else if (state == REQ || state == WAIT)
            cnt <= cnt + 1'b1;
    end

    // >= rather than == so a grant taken in the expiry cycle still times out in WAIT
    assign timeout = (cnt >= CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_bad ? RESP : REQ;
            REQ: begin
                if (rsp_take)       state_nxt = RESP;
                else if (mem_gnt)   state_nxt = WAIT;
                else if (to_expire) state_nxt = RESP;
            end
            WAIT: if (rsp_take || to_expire) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = (state == REQ);
        resp_valid = (state == RESP);
        resp_fault = (state == RESP) && fault_q;
    end

    // Request capture, bus drive registers and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
            fault_q     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            resp_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    op_q    <= req_op;
                    off_q   <= req_off;
                    fault_q <= req_bad;
                    if (req_bad) begin
                        resp_data_q <= '0;
                    end else begin
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[WIDTH-1:OFFW], {OFFW{1'b0}}};
                        mem_wstrb <= req_we ? (size_lanes << req_off) : '0;
                        mem_wdata <= req_wdata << {req_off, 3'b000};
                    end
                end
                REQ, WAIT: begin
                    if (rsp_take) begin
                        resp_data_q <= we_q ? '0 : load_ext;
                    end else if (to_expire) begin
                        resp_data_q <= '0;
                        fault_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_data = resp_data_q;

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Sequences one data-memory access at a time between the core's memory stage and a valid/ready data bus.
- Aligns the address and builds byte strobes.
- Waits for the bus response, then extracts and sign/zero-extends load data.
- Uses the team's standard load_op encoding (0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu).
- Misaligned and reserved accesses are rejected without touching the bus.

Parameters:
- WIDTH, 64, data/address width in bits; 32 or 64 only.
- NBYTES, WIDTH/8, bus byte lanes; derived, not overridable.
- TIMEOUT_CYCLES, 255, response watchdog limit. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  core access request.
- req_ready  out  1  controller accepts a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  load_op encoding for loads; for stores, size in op[1:0] (0 byte, 1 half, 2 word, 3 dword).
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  WIDTH  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned, reserved op, or timeout; valid with resp_valid.
- mem_req  out  1  bus request; held until mem_gnt.
- mem_we  out  1  bus write enable.
- mem_addr  out  WIDTH  req_addr with low log2(NBYTES) bits cleared.
- mem_wstrb  out  NBYTES  byte strobes.
- mem_wdata  out  WIDTH  store data shifted to its byte lane.
- mem_gnt  in  1  bus accepted request this cycle.
- mem_rvalid  in  1  bus response (read data or write ack).
- mem_rdata  in  WIDTH  full-width read data.

Behaviour:
- Reset: async; state IDLE. All outputs 0 except req_ready = 1. Reset mid-access abandons the access; no resp_valid is issued for it.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready = 1. Capture req_* on req_valid.
  - Misaligned access (address not a multiple of the access size), req_op = 7 on a load, or a dword/ld/lwu when WIDTH = 32 → RESP with fault = 1. No bus activity.
  - Otherwise → REQ.
- REQ:
  - mem_req = 1; mem_addr, mem_we, mem_wstrb and mem_wdata are stable from registered values.
  - mem_gnt → WAIT.
  - mem_gnt and mem_rvalid in the same cycle: treat the response as received → RESP.
- WAIT:
  - mem_req = 0. mem_rvalid → latch mem_rdata → RESP.
  - mem_rvalid in any other state is ignored.
- RESP: resp_valid = 1 for exactly one cycle → IDLE. req_ready returns to 1 on the following cycle.
- Minimum latency: accept at cycle N, mem_req at N+1, response at the grant cycle or later, resp_valid one cycle after the response. A fault responds at N+1.
- Strobes: byte 1 lane, half 2 lanes, word 4 lanes, dword all lanes. Lanes start at offset = addr[log2(NBYTES)-1:0]. mem_wdata = req_wdata << (8*offset). mem_wstrb = 0 for loads.
- Load extraction: shifted = mem_rdata >> (8*offset), then extend per load_op:
  - 0: sign-extend bits 7:0. 4: zero-extend bits 7:0.
  - 1: sign-extend bits 15:0. 5: zero-extend bits 15:0.
  - 2: sign-extend bits 31:0. 6: zero-extend bits 31:0.
  - 3: pass through.
- resp_data holds its value outside resp_valid and is 0 after a store or fault.
- Back-to-back: a new request can be accepted no earlier than the cycle after resp_valid.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider counter cleared on entry to REQ, incremented each cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES without the needed mem_gnt or mem_rvalid forces RESP with resp_fault = 1 and resp_data = 0, and drops mem_req.
  - A response arriving in the expiry cycle takes priority over the timeout.
- Undefined: no counter; the controller waits indefinitely.

Test Plan:
- lb at addr 0x1003, mem_rdata 0x00000000_80000000 → mem_addr 0x1000, resp_data 0xFFFFFFFF_FFFFFF80, fault 0.
- lhu at addr 0x2006, mem_rdata 0xBEEF0000_00000000 → resp_data 0x00000000_0000BEEF; lh at the same address → 0xFFFFFFFF_FFFFBEEF.
- sh at addr 0x10, wdata 0x1234, grant delayed 3 cycles → mem_req held 4 cycles, mem_wstrb 0x03, mem_wdata low half 0x1234, resp_valid after mem_rvalid with resp_data 0.
- lw at addr 0x1002 (misaligned) → mem_req never asserted, resp_valid at N+1 with fault 1; req_op 7 load → same.
- Reset asserted in WAIT, mem_rvalid pulsed after release → no resp_valid, req_ready = 1, next ld at 0x08 returns mem_rdata unmodified.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_gnt never asserted → resp_valid with fault 1 after 8 cycles in REQ, mem_req deasserted.
